// File: rtl/xor_result_packer.sv
// Packs the 1-bit XOR result stream LSB-first into WIDTH-bit words and queues them
// for a valid/ready consumer. Optional: `define RESULT_PARITY_EN adds out_parity.
module xor_result_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_bit,
    input  logic                     flush,
    input  logic                     out_ready,
    input  logic                     clr_err,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(WIDTH):0]   out_len,
    output logic [$clog2(WIDTH):0]   fill_cnt,
    output logic                     overflow
`ifdef RESULT_PARITY_EN
    ,
    output logic                     out_parity
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = $clog2(DEPTH);

    // Handshake: a word transfers on the rising edge where out_valid && out_ready;
    // the head holds steady otherwise. The input side cannot be stalled.

    typedef enum logic {
        S_IDLE,
        S_FILL
    } acc_state_e;

    acc_state_e        state_q;
    logic [WIDTH-1:0]  acc_q;
    logic [CW-1:0]     cnt_q;

    logic [WIDTH-1:0]  acc_d;
    logic [CW-1:0]     cnt_d;
    logic              push;

    logic [WIDTH-1:0]  mem_data [DEPTH];
    logic [CW-1:0]     mem_len  [DEPTH];
`ifdef RESULT_PARITY_EN
    logic              mem_par  [DEPTH];
`endif
    logic [AW-1:0]     rd_q, wr_q;
    logic [AW:0]       used_q;
    logic              ovf_q;

    logic              full, pop, wr_en, drop;

    // acc_d/cnt_d describe the word including this cycle's bit; the commit
    // decision is taken on that view so a completing bit plus flush makes one word.
    always_comb begin
        acc_d = (state_q == S_IDLE) ? '0 : acc_q;
        cnt_d = cnt_q;
        if (in_valid) begin
            acc_d = acc_d | (WIDTH'(in_bit) << cnt_q);
            cnt_d = cnt_q + CW'(1);
        end
        push = (cnt_d == CW'(WIDTH)) || (flush && (cnt_d != '0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (push) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (in_valid) begin
            state_q <= S_FILL;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign full  = (used_q == (AW+1)'(DEPTH));
    assign pop   = (used_q != '0) && out_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            used_q <= '0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_len[i]  <= '0;
`ifdef RESULT_PARITY_EN
                mem_par[i]  <= 1'b0;
`endif
            end
        end else begin
            if (wr_en) begin
                mem_data[wr_q] <= acc_d;
                mem_len[wr_q]  <= cnt_d;
`ifdef RESULT_PARITY_EN
                mem_par[wr_q]  <= ^acc_d;
`endif
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (wr_en && !pop) begin
                used_q <= used_q + (AW+1)'(1);
            end else if (pop && !wr_en) begin
                used_q <= used_q - (AW+1)'(1);
            end
            // A drop wins over a simultaneous clear so no loss goes unreported.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_err) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign out_valid = (used_q != '0);
    assign out_data  = out_valid ? mem_data[rd_q] : '0;
    assign out_len   = out_valid ? mem_len[rd_q]  : '0;
    assign fill_cnt  = cnt_q;
    assign overflow  = ovf_q;
`ifdef RESULT_PARITY_EN
    assign out_parity = out_valid ? mem_par[rd_q] : 1'b0;
`endif

endmodule

// File: tb/tb_xor_result_packer.sv
// Randomized and directed bench for xor_result_packer against a queue-based model.
module tb_xor_result_packer;
  localparam int W = 8;
  localparam int D = 2;
  localparam int CW = $clog2(W) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_bit = 1'b0, flush = 1'b0, out_ready = 1'b0, clr_err = 1'b0;
  logic out_valid, overflow;
  logic [W-1:0] out_data;
  logic [CW-1:0] out_len, fill_cnt;
`ifdef RESULT_PARITY_EN
  logic out_parity;
`endif

  xor_result_packer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .flush(flush),
    .out_ready(out_ready), .clr_err(clr_err), .out_valid(out_valid),
    .out_data(out_data), .out_len(out_len), .fill_cnt(fill_cnt), .overflow(overflow)
`ifdef RESULT_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: pending bits, queued words, sticky flag
  bit bits_q[$];
  logic [W-1:0] exp_q[$];
  int exp_len_q[$];
  bit exp_ovf = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_clear();
    bits_q.delete();
    exp_q.delete();
    exp_len_q.delete();
    exp_ovf = 1'b0;
  endtask

  task automatic model_edge();
    bit drop;
    logic [W-1:0] w;
    drop = 1'b0;
    if (in_valid) bits_q.push_back(in_bit);
    if (exp_q.size() > 0 && out_ready) begin
      void'(exp_q.pop_front());
      void'(exp_len_q.pop_front());
    end
    if (bits_q.size() == W || (flush && bits_q.size() > 0)) begin
      w = '0;
      foreach (bits_q[i]) w[i] = bits_q[i];
      if (exp_q.size() < D) begin
        exp_q.push_back(w);
        exp_len_q.push_back(bits_q.size());
      end else begin
        drop = 1'b1;
      end
      bits_q.delete();
    end
    if (drop) exp_ovf = 1'b1;
    else if (clr_err) exp_ovf = 1'b0;
  endtask

  task automatic compare_all();
    bit v;
    v = exp_q.size() > 0;
    check_eq("out_valid", 32'(out_valid), 32'(v));
    check_eq("out_data", 32'(out_data), v ? 32'(exp_q[0]) : 32'd0);
    check_eq("out_len", 32'(out_len), v ? 32'(exp_len_q[0]) : 32'd0);
    check_eq("fill_cnt", 32'(fill_cnt), 32'(bits_q.size()));
    check_eq("overflow", 32'(overflow), 32'(exp_ovf));
`ifdef RESULT_PARITY_EN
    check_eq("out_parity", 32'(out_parity), v ? 32'(^exp_q[0]) : 32'd0);
`endif
  endtask

  // driver: apply one cycle of inputs, advance the model, check on the falling edge
  task automatic step(input logic v, input logic b, input logic f, input logic r, input logic c);
    in_valid = v; in_bit = b; flush = f; out_ready = r; clr_err = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic r);
    for (int i = 0; i < W; i++) step(1'b1, w[i], 1'b0, r, 1'b0);
  endtask

  initial begin
    logic [W-1:0] pat;
    pat = 8'b0100_1101;
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b1;

    // eight bits 1,0,1,1,0,0,1,0 with consumer ready
    send_word(pat, 1'b1);
    check_eq("tp1_data", 32'(out_data), 32'h4D);
    check_eq("tp1_len", 32'(out_len), 32'd8);
    check_eq("tp1_fill", 32'(fill_cnt), 32'd0);
`ifdef RESULT_PARITY_EN
    check_eq("tp1_par", 32'(out_parity), 32'd0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("tp1_popped", 32'(out_valid), 32'd0);

    // partial word then flush, then an empty flush
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("tp2_data", 32'(out_data), 32'h03);
    check_eq("tp2_len", 32'(out_len), 32'd3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("tp2_no_empty_word", 32'(out_valid), 32'd0);

    // partial 1,1,1 with flush on the last bit
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("tp2b_data", 32'(out_data), 32'h07);
    check_eq("tp2b_len", 32'(out_len), 32'd3);
`ifdef RESULT_PARITY_EN
    check_eq("tp2b_par", 32'(out_parity), 32'd1);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // three words into a two-entry queue with the consumer stalled
    send_word(8'hFF, 1'b0);
    send_word(8'h0F, 1'b0);
    send_word(8'hA5, 1'b0);
    check_eq("tp3_ovf", 32'(overflow), 32'd1);
    check_eq("tp3_head0", 32'(out_data), 32'hFF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("tp3_head1", 32'(out_data), 32'h0F);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("tp3_drained", 32'(out_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("tp3_clr", 32'(overflow), 32'd0);

    // full queue, pop on the commit edge: no drop
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    for (int i = 0; i < W - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("tp4_no_ovf", 32'(overflow), 32'd0);
    check_eq("tp4_head", 32'(out_data), 32'h22);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("tp4_tail", 32'(out_data), 32'hFF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // asynchronous reset mid-word with one word queued
    send_word(8'h5A, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("tp5_pre_fill", 32'(fill_cnt), 32'd5);
    #2 rst = 1'b0;
    #1;
    model_clear();
    check_eq("tp5_async_valid", 32'(out_valid), 32'd0);
    check_eq("tp5_async_fill", 32'(fill_cnt), 32'd0);
    check_eq("tp5_async_data", 32'(out_data), 32'd0);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("tp5_nothing", 32'(out_valid), 32'd0);
    send_word(8'hC3, 1'b0);
    check_eq("tp5_word", 32'(out_data), 32'hC3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("tp5_one_word", 32'(out_valid), 32'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 29) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/xor_result_packer.md
Name: xor_result_packer

Overview:
- Downstream stage of the delayed XOR datapath.
- Consumes the 1-bit result stream that drains every cycle from the output FIFO, packs it LSB-first into WIDTH-bit words, and presents the words to a consumer over a valid/ready handshake.
- A DEPTH-entry word queue absorbs consumer stalls. The source cannot be back-pressured, so any loss is flagged as a sticky overflow.

Parameters:
- WIDTH, 8, bits per packed word; legal range 2..32.
- DEPTH, 2, output word queue entries; power of two, 2..8.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_bit carries a result this cycle.
- in_bit  input  1  XOR result bit.
- flush  input  1  emit the partially filled word now.
- out_ready  input  1  consumer accepts the head word.
- clr_err  input  1  synchronous clear of overflow.
- out_valid  output  1  queue head is valid.
- out_data  output  WIDTH  head word; bit i = i-th bit accepted into that word.
- out_len  output  $clog2(WIDTH)+1  number of valid bits in head word (1..WIDTH).
- fill_cnt  output  $clog2(WIDTH)+1  bits currently held in the accumulator (0..WIDTH-1).
- overflow  output  1  sticky: a word was dropped.

Behaviour:
- Reset (rst low, asynchronous): accumulator cleared, fill_cnt=0, queue empty, out_valid=0, out_data=0, out_len=0, overflow=0. Reset asserted mid-word or with queue occupied discards everything; nothing is emitted after release.
- Accumulator FSM:
  - IDLE (fill_cnt=0) -> FILL on in_valid.
  - FILL -> COMMIT when the accepted bit makes the count WIDTH, or on flush.
  - COMMIT is the same-edge push; it returns to IDLE with the accumulator zeroed.
  - Accepted bit is written at position fill_cnt; fill_cnt increments.
- Full word: the edge that accepts the WIDTH-th bit pushes {data, len=WIDTH}. out_valid is high in the following cycle when the queue was empty (latency 1 cycle from last bit).
- Flush:
  - flush with fill_cnt>0 pushes the partial word with out_len=fill_cnt; unfilled upper bits are 0.
  - flush with in_valid in the same cycle: the bit is included first, then the word is pushed. If that bit completes the word, exactly one full word is pushed.
  - flush with fill_cnt=0 and in_valid=0: no-op, no zero-length word.
- Queue:
  - FIFO order. Pop occurs on clk edge with out_valid && out_ready.
  - out_data/out_len are stable while out_valid=1 and out_ready=0.
  - out_data=0 and out_len=0 when empty.
- Push and pop in the same cycle:
  - Always legal, including when full (pop frees the slot).
  - Occupancy is unchanged.
  - When empty, no pop occurs; the push is visible next cycle.
- Push when full with no pop: the word is dropped, overflow sets, and the accumulator still clears. The queue contents are untouched.
- overflow clears only on clr_err. If clr_err and a drop occur in the same cycle, overflow ends at 1.
- in_valid=0 cycles are ignored; there is no timeout flush.
- No combinational path from in_* to out_*. out_ready affects only the next-edge state.

Optional Feature:
- Macro RESULT_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = XOR of the head word's valid bits; 0 when empty.
  - Parity is stored in the queue alongside each word and is stable with out_data.
- Undefined: port and storage absent; all other behaviour identical.

Test Plan:
- WIDTH=8. After reset, 8 cycles in_valid=1 with bits 1,0,1,1,0,0,1,0, out_ready=1 -> one cycle after the 8th bit: out_valid=1, out_data=8'h4D, out_len=8, popped next edge; fill_cnt back to 0.
- 3 bits 1,1,0 then flush alone -> out_data=8'h03, out_len=3. A second flush with fill_cnt=0 produces no word.
- out_ready=0, push 3 full words (all-ones, 8'h0F pattern, 8'hA5) with DEPTH=2 -> first two held in order, third dropped, overflow=1. Raise out_ready -> 8'hFF then 8'h0F drain. clr_err -> overflow=0.
- Queue full, out_ready=1 on the cycle the next word commits -> no drop, overflow stays 0, occupancy stays 2.
- rst low asynchronously mid-word (fill_cnt=5) with one queued word -> out_valid falls without a clock edge, fill_cnt=0. After release, 8 new bits produce exactly one word.
- RESULT_PARITY_EN defined, word 8'h4D -> out_parity=0. Partial word 8'h07 (len 3) -> out_parity=1.
